// File: rtl/period_generator.sv
// Programmable square-wave burst generator timed from an internal 1 ms tick.
// Define PERIOD_GEN_DUTY_EN to add the `hi` port for a programmable high time.
module period_generator #(
  parameter int CLK_MS_COUNT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] prd,
  input  logic [7:0] num,
`ifdef PERIOD_GEN_DUTY_EN
  input  logic [9:0] hi,
`endif
  output logic       so,
  output logic       ready,
  output logic       done_tick
);

  localparam int TW = (CLK_MS_COUNT > 1) ? $clog2(CLK_MS_COUNT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_MS_COUNT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic [9:0]    ms_cnt;
  logic [7:0]    prd_cnt;
  logic [9:0]    prd_q;
  logic [7:0]    num_q;
`ifdef PERIOD_GEN_DUTY_EN
  logic [9:0]    hi_q;
`endif

  logic [9:0] h_len, l_len;
  logic       req_ok;
  logic       tick_wrap;
  logic [9:0] ms_inc;
  logic [7:0] prd_inc;
  logic       h_hit, l_hit;

  // Phase lengths come from latched values only, so input changes mid-burst are harmless.
`ifdef PERIOD_GEN_DUTY_EN
  assign h_len  = hi_q;
  assign l_len  = prd_q - hi_q;
  assign req_ok = (num != 8'd0) && (prd >= 10'd2) && (hi != 10'd0) && (hi < prd);
`else
  assign h_len  = prd_q - (prd_q >> 1);
  assign l_len  = prd_q >> 1;
  assign req_ok = (num != 8'd0) && (prd >= 10'd2);
`endif

  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign ms_inc    = ms_cnt + 10'd1;
  assign prd_inc   = prd_cnt + 8'd1;
  assign h_hit     = tick_wrap && (ms_inc == h_len);
  assign l_hit     = tick_wrap && (ms_inc == l_len);

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = req_ok ? S_HIGH : S_DONE;
      S_HIGH: if (h_hit) state_nxt = S_LOW;
      S_LOW:  if (l_hit) state_nxt = (prd_inc == num_q) ? S_DONE : S_HIGH;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each changes at most once per cycle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      // NOTE: latched request registers are reset too; they are few and it keeps state deterministic.
      state     <= S_IDLE;
      so        <= 1'b0;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      tick_cnt  <= '0;
      ms_cnt    <= '0;
      prd_cnt   <= '0;
      prd_q     <= '0;
      num_q     <= '0;
`ifdef PERIOD_GEN_DUTY_EN
      hi_q      <= '0;
`endif
    end else begin
      state     <= state_nxt;
      so        <= (state_nxt == S_HIGH);
      ready     <= (state_nxt == S_IDLE);
      done_tick <= (state_nxt == S_DONE);

      case (state)
        S_IDLE: begin
          tick_cnt <= '0;
          ms_cnt   <= '0;
          prd_cnt  <= '0;
          if (start) begin
            prd_q <= prd;
            num_q <= num;
`ifdef PERIOD_GEN_DUTY_EN
            hi_q  <= hi;
`endif
          end
        end
        S_HIGH: begin
          tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
          if (tick_wrap) ms_cnt <= h_hit ? 10'd0 : ms_inc;
        end
        S_LOW: begin
          tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
          if (tick_wrap) ms_cnt <= l_hit ? 10'd0 : ms_inc;
          if (l_hit) prd_cnt <= prd_inc;
        end
        default: begin
          tick_cnt <= '0;
          ms_cnt   <= '0;
          prd_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_generator.sv
// Scoreboard bench for period_generator with CLK_MS_COUNT=4: stimulus pushes expected
// output events (edge kind + cycle), a negedge monitor detects and compares them.
module tb_period_generator;

  typedef enum int {EV_RDY_DN, EV_RISE, EV_FALL, EV_DONE, EV_RDY_UP} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] prd;
  logic [7:0] num;
  logic [9:0] hi;
  logic       so, ready, done_tick;

  int  ec = 0;
  int  t0 = 0;
  int  n_vec = 0;
  int  n_miss = 0;
  bit  mon_en = 1'b0;
  bit  prev_so, prev_rdy;
  ev_t exp_q[$];

  period_generator #(.CLK_MS_COUNT(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .prd(prd),
    .num(num),
`ifdef PERIOD_GEN_DUTY_EN
    .hi(hi),
`endif
    .so(so),
    .ready(ready),
    .done_tick(done_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ec++;

  task automatic check(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, ec, act, req);
    end
  endtask

  task automatic observe(input ev_kind_t kind, input int cyc);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL unexpected event %s at cycle %0d (rel %0d)", kind.name(), cyc, cyc - t0);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_miss++;
        $display("FAIL event: got %s at rel cycle %0d, expected %s at rel cycle %0d",
                 kind.name(), cyc - t0, e.kind.name(), e.cyc - t0);
      end
    end
  endtask

  // Event order inside one cycle is fixed; expectations are pushed in the same order.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_rdy && !ready) observe(EV_RDY_DN, ec + 1);
      if (!prev_so && so)     observe(EV_RISE, ec + 1);
      if (prev_so && !so)     observe(EV_FALL, ec + 1);
      if (done_tick)          observe(EV_DONE, ec + 1);
      if (!prev_rdy && ready) observe(EV_RDY_UP, ec + 1);
      prev_so  = so;
      prev_rdy = ready;
    end
  end

  task automatic expect_ev(input ev_kind_t kind, input int rel);
    ev_t e;
    e.kind = kind;
    e.cyc  = t0 + rel;
    exp_q.push_back(e);
  endtask

  // Drives a one-cycle start; the edge after this negedge is cycle 0 (t0).
  task automatic issue(input int p, input int n, input int h);
    @(negedge clk);
    prd   = 10'(p);
    num   = 8'(n);
    hi    = 10'(h);
    start = 1'b1;
    t0    = ec + 1;
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
    prd   = 10'd1023;
    num   = 8'd255;
    hi    = 10'd0;
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while (exp_q.size() != 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s timeout: %0d events outstanding", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_invalid();
    expect_ev(EV_RDY_DN, 1);
    expect_ev(EV_DONE, 1);
    expect_ev(EV_RDY_UP, 2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    prd   = '0;
    num   = '0;
    hi    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset so", so, 1'b0);
    check("reset ready", ready, 1'b1);
    check("reset done_tick", done_tick, 1'b0);
    prev_so  = so;
    prev_rdy = ready;
    mon_en   = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle ready", ready, 1'b1);
      check("idle so", so, 1'b0);
      check("idle done_tick", done_tick, 1'b0);
    end

    // prd=4 num=2: high 1-8, low 9-16, high 17-24, low 25-32, done 33, ready 34
    issue(4, 2, 2);
    expect_ev(EV_RDY_DN, 1);
    expect_ev(EV_RISE, 1);
    expect_ev(EV_FALL, 9);
    expect_ev(EV_RISE, 17);
    expect_ev(EV_FALL, 25);
    expect_ev(EV_DONE, 33);
    expect_ev(EV_RDY_UP, 34);
    release_start();
    drain("prd4_num2");

    // prd=5 num=1: odd period puts the extra ms in the high phase
    issue(5, 1, 3);
    expect_ev(EV_RDY_DN, 1);
    expect_ev(EV_RISE, 1);
    expect_ev(EV_FALL, 13);
    expect_ev(EV_DONE, 21);
    expect_ev(EV_RDY_UP, 22);
    release_start();
    drain("prd5_num1");

    // prd=2 num=3: shortest valid period, one ms each phase
    issue(2, 3, 1);
    expect_ev(EV_RDY_DN, 1);
    expect_ev(EV_RISE, 1);
    expect_ev(EV_FALL, 5);
    expect_ev(EV_RISE, 9);
    expect_ev(EV_FALL, 13);
    expect_ev(EV_RISE, 17);
    expect_ev(EV_FALL, 21);
    expect_ev(EV_DONE, 25);
    expect_ev(EV_RDY_UP, 26);
    release_start();
    drain("prd2_num3");

    issue(4, 0, 2);
    expect_invalid();
    release_start();
    drain("num0");

    issue(1, 3, 1);
    expect_invalid();
    release_start();
    drain("prd1");

    issue(0, 1, 0);
    expect_invalid();
    release_start();
    drain("prd0");

    // Second start at cycle 5 of a prd=4 num=1 burst must not disturb it
    issue(4, 1, 2);
    expect_ev(EV_RDY_DN, 1);
    expect_ev(EV_RISE, 1);
    expect_ev(EV_FALL, 9);
    expect_ev(EV_DONE, 17);
    expect_ev(EV_RDY_UP, 18);
    release_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    prd   = 10'd2;
    num   = 8'd1;
    @(negedge clk);
    start = 1'b0;
    drain("restart_ignored");

    // Reset sampled at cycle 6: so low and ready back at cycle 7, no done_tick
    issue(4, 1, 2);
    expect_ev(EV_RDY_DN, 1);
    expect_ev(EV_RISE, 1);
    expect_ev(EV_FALL, 7);
    expect_ev(EV_RDY_UP, 7);
    release_start();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drain("mid_reset");
    repeat (40) @(negedge clk);

`ifdef PERIOD_GEN_DUTY_EN
    issue(6, 1, 6);
    expect_invalid();
    release_start();
    drain("hi_eq_prd");

    issue(6, 1, 0);
    expect_invalid();
    release_start();
    drain("hi_zero");

    issue(10, 1, 3);
    expect_ev(EV_RDY_DN, 1);
    expect_ev(EV_RISE, 1);
    expect_ev(EV_FALL, 13);
    expect_ev(EV_DONE, 41);
    expect_ev(EV_RDY_UP, 42);
    release_start();
    drain("prd10_hi3");
`endif

    check("final ready", ready, 1'b1);
    check("final so", so, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
